// File: rtl/wrf_loss_injector.sv
// Frame-loss injector for the WR fabric. Sits between a fabric source and
// sink and discards whole frames by fragment mask, by LFSR probability, or
// in LFSR-triggered bursts. Forwarded frames are passed through
// combinationally. Dropped frames are acked locally, one cycle after each
// strobe. Forward and drop counters and the control registers sit on a
// pipelined Wishbone slave.
module wrf_loss_injector #(
    parameter int          g_group_size = 4,
    parameter logic [31:0] g_lfsr_seed  = 32'hACE12468,
    parameter int          g_cnt_width  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        snk_cyc,
    input  logic        snk_stb,
    input  logic        snk_we,
    input  logic [1:0]  snk_sel,
    input  logic [1:0]  snk_adr,
    input  logic [15:0] snk_dat,
    output logic        snk_ack,
    output logic        snk_stall,
    output logic        src_cyc,
    output logic        src_stb,
    output logic        src_we,
    output logic [1:0]  src_sel,
    output logic [1:0]  src_adr,
    output logic [15:0] src_dat,
    input  logic        src_ack,
    input  logic        src_stall,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [2:0]  wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        wb_stall
);

    localparam logic [3:0]  IDX_LAST   = 4'(g_group_size - 1);
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003; // x^32+x^22+x^2+x+1
    localparam logic [1:0]  MODE_MASK  = 2'd0;
    localparam logic [1:0]  MODE_RAND  = 2'd1;
    localparam logic [1:0]  MODE_BURST = 2'd2;

    // configuration registers
    logic [2:0]              ctrl_reg;        // {mode[1:0], en}
    logic [g_group_size-1:0] mask_reg;
    logic [15:0]             prob_reg;
    logic [7:0]              burst_len_reg;
    logic                    clr_reg;

    // frame tracking and decision state
    logic [31:0]             lfsr_reg;
    logic [3:0]              idx_reg;
    logic [7:0]              burst_rem_reg;
    logic [7:0]              burst_rem_next;
    logic                    in_frame_reg;
    logic                    drop_reg;
    logic                    orphan_reg;      // tail of a frame that straddled reset
    logic                    cyc_d_reg;
    logic                    ack_reg;
    logic [g_cnt_width-1:0]  cnt_fwd_reg;
    logic [g_cnt_width-1:0]  cnt_drop_reg;

    logic                    wb_ack_reg;
    logic [31:0]             wb_dat_reg;
    logic [31:0]             rd_data;

    logic        en;
    logic [1:0]  mode;
    logic        frame_start;
    logic        frame_end;
    logic        lfsr_hit;
    logic        drop_dec;
    logic        dropping;
    logic        forwarding;
    logic [15:0] mask_ext;
    logic [31:0] lfsr_next;
    logic        unused_ok;

    assign en          = ctrl_reg[0];
    assign mode        = ctrl_reg[2:1];
    assign frame_start = snk_cyc & ~cyc_d_reg & ~orphan_reg;
    assign frame_end   = ~snk_cyc & in_frame_reg;
    assign lfsr_hit    = lfsr_reg[15:0] < prob_reg;
    assign lfsr_next   = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'h0);

    // widen the mask to 16 bits so any fragment index selects cleanly
    for (genvar gi = 0; gi < 16; gi++) begin : g_mask_ext
        if (gi < g_group_size) begin : g_used
            assign mask_ext[gi] = mask_reg[gi];
        end else begin : g_pad
            assign mask_ext[gi] = 1'b0;
        end
    end

    // frame-start drop decision and next burst countdown
    always_comb begin
        drop_dec       = 1'b0;
        burst_rem_next = burst_rem_reg;
        if (!en) begin
            burst_rem_next = 8'd0;
        end else if (frame_start) begin
            case (mode)
                MODE_MASK: drop_dec = mask_ext[idx_reg];
                MODE_RAND: drop_dec = lfsr_hit;
                MODE_BURST: begin
                    if (burst_rem_reg != 8'd0) begin
                        drop_dec       = 1'b1;
                        burst_rem_next = burst_rem_reg - 8'd1;
                    end else if (lfsr_hit) begin
                        drop_dec       = 1'b1;
                        burst_rem_next = (burst_len_reg == 8'd0) ? 8'd0 : burst_len_reg - 8'd1;
                    end
                end
                default: drop_dec = 1'b0;
            endcase
        end
    end

    // the decision is live on the frame-start cycle so forwarding adds no latency
    assign dropping   = orphan_reg | (frame_start ? drop_dec : (in_frame_reg & drop_reg));
    assign forwarding = ~rst_i & ~dropping;

    assign src_cyc   = forwarding & snk_cyc;
    assign src_stb   = forwarding & snk_stb;
    assign src_we    = forwarding & snk_we;
    assign src_sel   = forwarding ? snk_sel : 2'b0;
    assign src_adr   = forwarding ? snk_adr : 2'b0;
    assign src_dat   = forwarding ? snk_dat : 16'h0;
    assign snk_stall = forwarding & src_stall;
    assign snk_ack   = ~rst_i & (ack_reg | (forwarding & src_ack));

    assign wb_ack    = ~rst_i & wb_ack_reg;
    assign wb_dat_o  = rst_i ? 32'h0 : wb_dat_reg;
    assign wb_stall  = 1'b0;
    assign unused_ok = &{1'b0, wb_sel, wb_dat_i[31:16]};

    // frame tracking, LFSR, fragment index, local acks and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_d_reg     <= snk_cyc;
            orphan_reg    <= snk_cyc;
            in_frame_reg  <= 1'b0;
            drop_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            lfsr_reg      <= g_lfsr_seed;
            idx_reg       <= 4'd0;
            burst_rem_reg <= 8'd0;
            cnt_fwd_reg   <= '0;
            cnt_drop_reg  <= '0;
        end else begin
            cyc_d_reg     <= snk_cyc;
            ack_reg       <= dropping & snk_cyc & snk_stb;
            burst_rem_reg <= burst_rem_next;
            if (!snk_cyc) begin
                orphan_reg <= 1'b0;
            end
            if (frame_start) begin
                in_frame_reg <= 1'b1;
                drop_reg     <= drop_dec;
                lfsr_reg     <= lfsr_next;
            end else if (frame_end) begin
                in_frame_reg <= 1'b0;
                drop_reg     <= 1'b0;
            end
            if (!en) begin
                idx_reg <= 4'd0;
            end else if (frame_end) begin
                idx_reg <= (idx_reg == IDX_LAST) ? 4'd0 : idx_reg + 4'd1;
            end
            if (clr_reg) begin
                cnt_fwd_reg  <= '0;
                cnt_drop_reg <= '0;
            end else if (frame_end) begin
                if (drop_reg) begin
                    if (~&cnt_drop_reg) cnt_drop_reg <= cnt_drop_reg + 1'b1;
                end else begin
                    if (~&cnt_fwd_reg) cnt_fwd_reg <= cnt_fwd_reg + 1'b1;
                end
            end
        end
    end

    // register read mux
    always_comb begin
        rd_data = 32'h0;
        case (wb_adr)
            3'd0: rd_data[2:0] = ctrl_reg;
            3'd1: rd_data[g_group_size-1:0] = mask_reg;
            3'd2: rd_data[15:0] = prob_reg;
            3'd3: rd_data[7:0] = burst_len_reg;
            3'd4: rd_data[g_cnt_width-1:0] = cnt_fwd_reg;
            3'd5: rd_data[g_cnt_width-1:0] = cnt_drop_reg;
            3'd6: rd_data[5:0] = {orphan_reg | (in_frame_reg & drop_reg), in_frame_reg, idx_reg};
            default: rd_data = 32'h0;
        endcase
    end

    // Wishbone slave: one-cycle ack, register writes, self-clearing CLR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_reg      <= 3'd0;
            mask_reg      <= '0;
            prob_reg      <= 16'h0;
            burst_len_reg <= 8'h0;
            clr_reg       <= 1'b0;
            wb_ack_reg    <= 1'b0;
            wb_dat_reg    <= 32'h0;
        end else begin
            wb_ack_reg <= wb_cyc & wb_stb;
            clr_reg    <= 1'b0;
            if (wb_cyc && wb_stb) begin
                wb_dat_reg <= rd_data;
                if (wb_we) begin
                    case (wb_adr)
                        3'd0: begin
                            ctrl_reg <= wb_dat_i[2:0];
                            clr_reg  <= wb_dat_i[3];
                        end
                        3'd1: mask_reg      <= wb_dat_i[g_group_size-1:0];
                        3'd2: prob_reg      <= wb_dat_i[15:0];
                        3'd3: burst_len_reg <= wb_dat_i[7:0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
